// File: rtl/eight_bit_demux_dispatcher_if.sv
// Handshake and channel bus for the 8-bit, 4-channel demux dispatcher.
interface eight_bit_demux_dispatcher_if;
    logic [7:0] a;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [1:0] dest;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic [7:0] out4;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       busy;
    logic [7:0] dispatch_cnt;

    modport master (
        output a, in_valid, mode, dest, out_ready,
        input  in_ready, out1, out2, out3, out4,
        input  out_valid, busy, dispatch_cnt
    );

    modport slave (
        input  a, in_valid, mode, dest, out_ready,
        output in_ready, out1, out2, out3, out4,
        output out_valid, busy, dispatch_cnt
    );
endinterface

// File: rtl/eight_bit_demux_dispatcher.sv
// Stages one byte and dispatches it into one of four single-entry
// channel buffers, chosen by dest or by a round-robin pointer.
module eight_bit_demux_dispatcher (
    input logic clk,
    input logic rst,
    eight_bit_demux_dispatcher_if.slave bus
);
    typedef enum logic {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] staging;
    logic [1:0] target;
    logic       target_rr;
    logic [1:0] rr_ptr;
    logic [7:0] chan [4];
    logic [3:0] valid;
    logic [7:0] cnt;
    logic       accept;
    logic       target_free;
    logic       dispatch;

    assign accept      = (state == IDLE) && bus.in_valid;
    assign target_free = !valid[target] || bus.out_ready[target];
    assign dispatch    = (state == DISPATCH) && target_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (bus.in_valid) state_nxt = DISPATCH;
            DISPATCH: if (target_free)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        unique case (state)
            IDLE:     bus.in_ready = 1'b1;
            DISPATCH: bus.busy     = 1'b1;
            default:  bus.in_ready = 1'b0;
        endcase
    end

    // Target and its routing mode are frozen at accept time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging   <= 8'h00;
            target    <= 2'd0;
            target_rr <= 1'b0;
        end else if (accept) begin
            staging   <= bus.a;
            target    <= bus.mode ? rr_ptr : bus.dest;
            target_rr <= bus.mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 2'd0;
            cnt    <= 8'h00;
        end else if (dispatch) begin
            cnt <= cnt + 8'd1;
            if (target_rr) rr_ptr <= rr_ptr + 2'd1;
        end
    end

    // A write into a channel wins over its drain on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 4'b0000;
            for (int k = 0; k < 4; k++) chan[k] <= 8'h00;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (dispatch && target == 2'(k)) begin
                    valid[k] <= 1'b1;
                    chan[k]  <= staging;
                end else if (valid[k] && bus.out_ready[k]) begin
                    valid[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.out1         = valid[0] ? chan[0] : 8'h00;
    assign bus.out2         = valid[1] ? chan[1] : 8'h00;
    assign bus.out3         = valid[2] ? chan[2] : 8'h00;
    assign bus.out4         = valid[3] ? chan[3] : 8'h00;
    assign bus.out_valid    = valid;
    assign bus.dispatch_cnt = cnt;
endmodule

// File: tb/tb_eight_bit_demux_dispatcher.sv
// Directed and randomized checks of the demux dispatcher against a
// transaction-level model of staging, channel buffers and counters.
module tb_eight_bit_demux_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b1;

    eight_bit_demux_dispatcher_if bus ();

    eight_bit_demux_dispatcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_buf [4];
    bit         m_vld [4];
    bit         m_idle;
    bit         m_tmode;
    int         m_tgt;
    int         m_rr;
    int         m_cnt;
    logic [7:0] m_stage;

    task automatic m_reset();
        for (int k = 0; k < 4; k++) begin
            m_buf[k] = 8'h00;
            m_vld[k] = 1'b0;
        end
        m_idle  = 1'b1;
        m_tmode = 1'b0;
        m_tgt   = 0;
        m_rr    = 0;
        m_cnt   = 0;
        m_stage = 8'h00;
    endtask

    // One clock of behaviour: accept, or try to place the staged byte.
    task automatic m_clock(input bit v, input logic [7:0] d, input bit md,
                           input int ds, input logic [3:0] rdy);
        bit free;
        if (m_idle) begin
            for (int k = 0; k < 4; k++)
                if (m_vld[k] && rdy[k]) m_vld[k] = 1'b0;
            if (v) begin
                m_stage = d;
                m_tgt   = md ? m_rr : ds;
                m_tmode = md;
                m_idle  = 1'b0;
            end
        end else begin
            free = !m_vld[m_tgt] || rdy[m_tgt];
            for (int k = 0; k < 4; k++)
                if (m_vld[k] && rdy[k]) m_vld[k] = 1'b0;
            if (free) begin
                m_vld[m_tgt] = 1'b1;
                m_buf[m_tgt] = m_stage;
                m_cnt        = (m_cnt + 1) % 256;
                if (m_tmode) m_rr = (m_rr + 1) % 4;
                m_idle = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0]  ov;
        logic [31:0] od;
        logic [31:0] obs_d;
        for (int k = 0; k < 4; k++) begin
            ov[k] = m_vld[k];
            od[8*k +: 8] = m_vld[k] ? m_buf[k] : 8'h00;
        end
        obs_d = {bus.out4, bus.out3, bus.out2, bus.out1};
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(m_idle));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(!m_idle));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".outs"}, obs_d, od);
        chk({tag, ".cnt"}, 32'(bus.dispatch_cnt), 32'(m_cnt));
    endtask

    task automatic step(input string tag, input bit v, input logic [7:0] d,
                        input bit md, input int ds, input logic [3:0] rdy);
        bus.in_valid  = v;
        bus.a         = d;
        bus.mode      = md;
        bus.dest      = 2'(ds);
        bus.out_ready = rdy;
        if (!rst) m_clock(v, d, md, ds, rdy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [7:0] d, input bit md,
                        input int ds, input logic [3:0] rdy);
        step(tag, 1'b1, d, md, ds, rdy);
        step(tag, 1'b0, 8'h00, md, ds, rdy);
    endtask

    initial begin
        int start;
        logic [7:0] rr_bytes [5];
        rr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus.a = 8'h00;
        bus.in_valid = 1'b0;
        bus.mode = 1'b0;
        bus.dest = 2'd0;
        bus.out_ready = 4'b0000;
        m_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed basic, accepted on first edge after release.
        send("basic", 8'hA5, 1'b0, 2, 4'b0000);
        chk("basic.ov", 32'(bus.out_valid), 32'h4);
        chk("basic.out3", 32'(bus.out3), 32'hA5);
        chk("basic.cnt", 32'(bus.dispatch_cnt), 32'h1);
        step("drain", 1'b0, 8'h00, 1'b0, 0, 4'b1111);

        for (int i = 0; i < 5; i++) begin
            send("rr", rr_bytes[i], 1'b1, 0, 4'b1111);
            chk("rr.target", 32'(bus.out_valid), 32'(4'b0001 << (i % 4)));
        end
        step("drain", 1'b0, 8'h00, 1'b0, 0, 4'b1111);

        // Stall on a full channel, then replace on the same edge.
        send("fill2", 8'h77, 1'b0, 1, 4'b0000);
        step("stall", 1'b1, 8'h3C, 1'b0, 1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b0, 8'h00, 1'b0, 1, 4'b0000);
            chk("stall.busy", 32'(bus.busy), 32'h1);
        end
        step("unstall", 1'b0, 8'h00, 1'b0, 1, 4'b0010);
        chk("unstall.out2", 32'(bus.out2), 32'h3C);
        chk("unstall.v2", 32'(bus.out_valid[1]), 32'h1);
        chk("unstall.idle", 32'(bus.in_ready), 32'h1);
        step("drain", 1'b0, 8'h00, 1'b0, 0, 4'b1111);

        // rr_ptr is 1 here; bring it to 3, then change mode mid-dispatch.
        send("rr", 8'h61, 1'b1, 0, 4'b1111);
        send("rr", 8'h62, 1'b1, 0, 4'b1111);
        step("drain", 1'b0, 8'h00, 1'b0, 0, 4'b1111);
        send("fill4", 8'h99, 1'b0, 3, 4'b0000);
        step("mchg", 1'b1, 8'hC4, 1'b1, 2, 4'b0000);
        step("mchg", 1'b0, 8'h00, 1'b0, 0, 4'b0000);
        step("mchg", 1'b0, 8'h00, 1'b0, 0, 4'b0000);
        step("mchg", 1'b0, 8'h00, 1'b0, 0, 4'b1000);
        chk("mchg.out4", 32'(bus.out4), 32'hC4);
        step("drain", 1'b0, 8'h00, 1'b0, 0, 4'b1111);
        send("rr0", 8'hD1, 1'b1, 3, 4'b0000);
        chk("rr0.target", 32'(bus.out_valid), 32'h1);
        chk("rr0.out1", 32'(bus.out1), 32'hD1);
        step("drain", 1'b0, 8'h00, 1'b0, 0, 4'b1111);

        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom), 8'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), 4'($urandom));
        while (!m_idle)
            step("settle", 1'b0, 8'h00, 1'b0, 0, 4'b1111);
        step("drain", 1'b0, 8'h00, 1'b0, 0, 4'b1111);

        start = m_cnt;
        for (int i = 0; i < 256; i++)
            send("wrap", 8'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), 4'b1111);
        chk("wrap.cnt", 32'(bus.dispatch_cnt), 32'(start));

        // Reset while busy with channels 1, 2 and 4 full.
        step("drain", 1'b0, 8'h00, 1'b0, 0, 4'b1111);
        send("hold", 8'h01, 1'b0, 0, 4'b0000);
        send("hold", 8'h02, 1'b0, 1, 4'b0000);
        send("hold", 8'h04, 1'b0, 3, 4'b0000);
        step("hold", 1'b1, 8'h08, 1'b0, 0, 4'b0000);
        chk("hold.ov", 32'(bus.out_valid), 32'hB);
        chk("hold.busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        m_reset();
        #1;
        check_all("rstmid");
        step("rsthold", 1'b0, 8'h00, 1'b0, 0, 4'b1111);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            step("postrst", 1'b0, 8'h00, 1'b0, 0, 4'b1111);
        send("postrst", 8'hE7, 1'b1, 2, 4'b0000);
        chk("postrst.rr", 32'(bus.out1), 32'hE7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/eight_bit_demux_dispatcher.md
EIGHT_BIT_DEMUX_DISPATCHER -- requirements
Module: eight_bit_demux_dispatcher

Interface
REQ-001 Parameters: none. Data width is fixed at 8 bits and the channel count is fixed at 4.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  8  input data byte.
- in_valid  in  1  input byte offered.
- in_ready  out  1  block can accept the offered byte.
- mode  in  1  0 = directed routing by dest; 1 = round-robin routing.
- dest  in  2  target channel in directed mode (0->out1, 1->out2, 2->out3, 3->out4).
- out1, out2, out3, out4  out  8 each  channel data.
- out_valid  out  4  bit k set = channel k+1 holds a byte.
- out_ready  in  4  bit k set = consumer of channel k+1 takes its byte.
- busy  out  1  staging register occupied.
- dispatch_cnt  out  8  count of bytes written into channel buffers.

Function
REQ-004 The block SHALL have a two-state FSM: IDLE and DISPATCH.
REQ-005 in_ready SHALL equal (state == IDLE); busy SHALL equal (state == DISPATCH).
REQ-006 Accept condition: in IDLE with in_valid=1.
- Capture a into the staging register.
- Capture the target: dest if mode=0, else the round-robin pointer rr_ptr.
- Go to DISPATCH.
REQ-007 mode and dest SHALL be sampled only at the accept edge; changes during DISPATCH SHALL NOT affect the captured target.
REQ-008 In DISPATCH, the target channel is free when its out_valid bit is 0, or when that bit is 1 and its out_ready bit is 1 in the same cycle.
REQ-009 In DISPATCH with the target free:
- Write the staged byte into that channel buffer and set its out_valid bit.
- Increment dispatch_cnt.
- Return to IDLE.
REQ-010 In DISPATCH with the target not free, the block SHALL stay in DISPATCH with staging unchanged (stall, no timeout).
REQ-011 Minimum latency: accept at edge N SHALL give target out_valid=1 after edge N+1. Peak throughput is one byte per 2 cycles.
REQ-012 rr_ptr SHALL advance 0->1->2->3->0 only on a dispatch whose byte was captured with mode=1. Directed dispatches SHALL leave rr_ptr unchanged.
REQ-013 Each channel buffer SHALL be one entry. out_valid[k] SHALL clear on the edge where out_valid[k]=1 and out_ready[k]=1, unless the same edge writes new data into channel k; then valid stays 1 and the data is replaced.
REQ-014 Channels not targeted SHALL drain independently. Multiple out_ready bits may be high at once, and all valid-and-ready channels clear in the same cycle.
REQ-015 Each outN SHALL read 8'h00 whenever its out_valid bit is 0 (unselected outputs zeroed, as a demux).
REQ-016 out_ready on a channel with out_valid=0 SHALL have no effect.
REQ-017 dispatch_cnt SHALL wrap 8'hFF -> 8'h00.

Reset
REQ-018 While rst=1, asynchronously:
- state=IDLE, in_ready=1, busy=0.
- rr_ptr=0, staging=8'h00.
- out_valid=4'b0000, out1..out4=8'h00.
- dispatch_cnt=8'h00.
REQ-019 Reset asserted during DISPATCH or with full buffers SHALL discard all held bytes. No output pulse or dispatch SHALL follow deassertion.
REQ-020 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-021 Directed basic: mode=0, dest=2, a=8'hA5, in_valid for 1 cycle, out_ready=0 -> two edges later out_valid=4'b0100, out3=8'hA5, others 8'h00, dispatch_cnt=1.
REQ-022 Round-robin: mode=1, bytes 11,22,33,44,55 sent with out_ready=4'b1111 -> delivered to out1,out2,out3,out4,out1 in order; rr_ptr ends at 1.
REQ-023 Stall: out2 full with out_ready[1]=0, send 8'h3C dest=1 -> busy=1 and in_ready=0 held. Raise out_ready[1] for 1 cycle -> same edge out2 becomes 8'h3C with valid staying 1, FSM returns to IDLE.
REQ-024 Mode change mid-op: accept with mode=1 (rr_ptr=3), flip mode=0 and dest=0 during DISPATCH -> byte lands on out4, rr_ptr becomes 0.
REQ-025 Reset mid-operation: assert rst while busy=1 and out_valid=4'b1011 -> all outputs are at reset values immediately, and nothing is delivered after release.
REQ-026 Counter wrap: 256 dispatches -> dispatch_cnt returns to 8'h00.
